// File: rtl/tw_stage_buf.sv
// tw_stage_buf: per-stage twiddle bank streamer with half-word reload port.
// Optional TW_CONST_WR_EN makes the per-stage constant table writable.
module tw_stage_buf #(
    parameter int P_WIDTH   = 128,
    parameter int HW_DW     = 64,
    parameter int NUM_STAGE = 4,
    parameter int GROUPS    = 4,
    parameter int DEPTH     = 4,
    parameter int REPEAT    = 16,
    parameter int SC_WIDTH  = 3,
    parameter logic [P_WIDTH-1:0] CONST_RST =
        {64'hfffffbff00000001, 64'h1fffffffe0000000},
    localparam int AW = $clog2(NUM_STAGE * GROUPS * DEPTH),
`ifdef TW_CONST_WR_EN
    localparam int WAW = AW + 1
`else
    localparam int WAW = AW
`endif
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                CEN,
    input  logic [SC_WIDTH-1:0] stage_counter,
    input  logic                adv_en,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic                wr_half,
    input  logic [WAW-1:0]      wr_addr,
    input  logic [HW_DW-1:0]    wr_data,
    output logic [P_WIDTH-1:0]  Q,
    output logic                q_valid,
    output logic [P_WIDTH-1:0]  Q_const
);

    localparam int NW = NUM_STAGE * GROUPS * DEPTH;
    localparam int SW = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [P_WIDTH-1:0] IDENT = {HW_DW'(1), HW_DW'(1)};

    logic [P_WIDTH-1:0]  bank_q [NW];
    logic [P_WIDTH-1:0]  q_q;
    logic                qv_q;
    logic [P_WIDTH-1:0]  qc_q;
    logic [DW-1:0]       idx_q, idx_d;
    logic [RW-1:0]       rep_q, rep_d;
    logic [GW-1:0]       grp_q, grp_d;
    logic [SC_WIDTH-1:0] stg_q;

    logic          we;
    logic          we_const;
    logic          in_rng;
    logic          chg;
    logic [SW-1:0] sidx;
    logic [DW-1:0] ei;
    logic [RW-1:0] er;
    logic [GW-1:0] eg;
    logic [AW-1:0] rd_addr;
    logic [P_WIDTH-1:0] const_rd;

    assign wr_ready = CEN;
    assign we       = wr_valid && CEN;
`ifdef TW_CONST_WR_EN
    assign we_const = wr_addr[AW];
`else
    assign we_const = 1'b0;
`endif

    assign in_rng = 32'(stage_counter) < NUM_STAGE;
    assign sidx   = stage_counter[SW-1:0];
    // A new stage restarts its walk at {stage, 0, 0}.
    assign chg    = stage_counter != stg_q;
    assign ei     = chg ? '0 : idx_q;
    assign er     = chg ? '0 : rep_q;
    assign eg     = chg ? '0 : grp_q;

    assign rd_addr = AW'(sidx) * AW'(GROUPS * DEPTH)
                   + AW'(eg) * AW'(DEPTH) + AW'(ei);

`ifdef TW_CONST_WR_EN
    logic [P_WIDTH-1:0] const_q [NUM_STAGE];

    // Writable constant table, selected by the address MSB.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) const_q[i] <= CONST_RST;
        end else if (we && we_const) begin
            if (wr_half) const_q[wr_addr[SW-1:0]][P_WIDTH-1:HW_DW] <= wr_data;
            else         const_q[wr_addr[SW-1:0]][HW_DW-1:0]       <= wr_data;
        end
    end

    assign const_rd = const_q[sidx];
`else
    assign const_rd = CONST_RST;
`endif

    // Half-word reloads into the twiddle banks while the reader is idle.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) bank_q[i] <= IDENT;
        end else if (we && !we_const) begin
            if (wr_half) bank_q[wr_addr[AW-1:0]][P_WIDTH-1:HW_DW] <= wr_data;
            else         bank_q[wr_addr[AW-1:0]][HW_DW-1:0]       <= wr_data;
        end
    end

    // Walk order: idx, then rep, then grp, all from the effective values.
    always_comb begin
        idx_d = idx_q;
        rep_d = rep_q;
        grp_d = grp_q;
        if (!CEN) begin
            if (!in_rng) begin
                idx_d = '0;
                rep_d = '0;
                grp_d = '0;
            end else if (adv_en) begin
                idx_d = ei + DW'(1);
                rep_d = er;
                grp_d = eg;
                if (ei == DW'(DEPTH - 1)) begin
                    idx_d = '0;
                    rep_d = er + RW'(1);
                    if (er == RW'(REPEAT - 1)) begin
                        rep_d = '0;
                        grp_d = (eg == GW'(GROUPS - 1)) ? '0 : eg + GW'(1);
                    end
                end
            end else begin
                idx_d = '0;
                rep_d = '0;
                grp_d = eg;
            end
        end
    end

    // Registered read port, constant output and walk counters.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= IDENT;
            qv_q  <= 1'b0;
            qc_q  <= CONST_RST;
            idx_q <= '0;
            rep_q <= '0;
            grp_q <= '0;
            stg_q <= '0;
        end else begin
            idx_q <= idx_d;
            rep_q <= rep_d;
            grp_q <= grp_d;
            if (CEN) begin
                q_q  <= IDENT;
                qv_q <= 1'b0;
            end else begin
                stg_q <= stage_counter;
                if (in_rng) begin
                    q_q  <= bank_q[rd_addr];
                    qv_q <= 1'b1;
                    qc_q <= const_rd;
                end else begin
                    q_q  <= IDENT;
                    qv_q <= 1'b0;
                end
            end
        end
    end

    assign Q       = q_q;
    assign q_valid = qv_q;
    assign Q_const = qc_q;

endmodule

// File: tb/tb_tw_stage_buf.sv
// tb_tw_stage_buf: directed bench for tw_stage_buf.
// Covers TW_CONST_WR_EN when the same macro is defined for the bench.
module tb_tw_stage_buf;

`ifdef TW_CONST_WR_EN
    localparam int WAW = 7;
`else
    localparam int WAW = 6;
`endif

    localparam logic [127:0] IDENT = {64'd1, 64'd1};
    localparam logic [127:0] CRST  =
        {64'hfffffbff00000001, 64'h1fffffffe0000000};

    logic           CLK;
    logic           rst_n;
    logic           CEN;
    logic [2:0]     stage_counter;
    logic           adv_en;
    logic           wr_valid;
    logic           wr_ready;
    logic           wr_half;
    logic [WAW-1:0] wr_addr;
    logic [63:0]    wr_data;
    logic [127:0]   Q;
    logic           q_valid;
    logic [127:0]   Q_const;

    int nchk;
    int nfail;

    logic [127:0] w [4];
    logic [127:0] g1w0;

    tw_stage_buf dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .CEN           (CEN),
        .stage_counter (stage_counter),
        .adv_en        (adv_en),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_half       (wr_half),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .Q             (Q),
        .q_valid       (q_valid),
        .Q_const       (Q_const)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [WAW-1:0] a, input logic h,
                      input logic [63:0] d);
        CEN      = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_half  = h;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        CEN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        nchk++;
        if (Q !== IDENT) begin
            nfail++;
            $display("FAIL reset_Q got %h want %h", Q, IDENT);
        end
        nchk++;
        if (q_valid !== 1'b0) begin
            nfail++;
            $display("FAIL reset_qv got %b want 0", q_valid);
        end
        nchk++;
        if (Q_const !== CRST) begin
            nfail++;
            $display("FAIL reset_Qc got %h want %h", Q_const, CRST);
        end
        nchk++;
        if (wr_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset_rdy got %b want 1", wr_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream_ident();
        CEN = 1'b0;
        stage_counter = 3'd0;
        adv_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            nchk++;
            if (Q !== IDENT || q_valid !== 1'b1 || Q_const !== CRST) begin
                nfail++;
                $display("FAIL ident_%0d got Q=%h v=%b Qc=%h want Q=%h v=1 Qc=%h",
                         k, Q, q_valid, Q_const, IDENT, CRST);
            end
        end
        adv_en = 1'b0;
        tick();
        CEN = 1'b1;
        tick();
    endtask

    task automatic test_load_stream();
        for (int i = 0; i < 4; i++) begin
            wr(WAW'(i), 1'b1, w[i][127:64]);
            wr(WAW'(i), 1'b0, w[i][63:0]);
        end
        wr(WAW'(4), 1'b1, g1w0[127:64]);
        wr(WAW'(4), 1'b0, g1w0[63:0]);
        CEN = 1'b0;
        stage_counter = 3'd0;
        adv_en = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick();
            nchk++;
            if (Q !== w[k % 4] || q_valid !== 1'b1) begin
                nfail++;
                $display("FAIL stream_%0d got %h v=%b want %h v=1",
                         k, Q, q_valid, w[k % 4]);
            end
        end
        tick();
        nchk++;
        if (Q !== g1w0) begin
            nfail++;
            $display("FAIL grp1_w0 got %h want %h", Q, g1w0);
        end
        tick();
        nchk++;
        if (Q !== IDENT) begin
            nfail++;
            $display("FAIL grp1_w1 got %h want %h", Q, IDENT);
        end
        stage_counter = 3'd5;
        tick();
        nchk++;
        if (Q !== IDENT || q_valid !== 1'b0) begin
            nfail++;
            $display("FAIL oor_clear got %h v=%b want %h v=0",
                     Q, q_valid, IDENT);
        end
    endtask

    task automatic test_wr_blocked();
        CEN = 1'b0;
        stage_counter = 3'd5;
        wr_valid = 1'b1;
        wr_addr = '0;
        wr_half = 1'b0;
        wr_data = 64'hdead_beef_dead_beef;
        #1;
        nchk++;
        if (wr_ready !== 1'b0) begin
            nfail++;
            $display("FAIL blk_rdy got %b want 0", wr_ready);
        end
        tick();
        wr_valid = 1'b0;
        stage_counter = 3'd0;
        adv_en = 1'b0;
        tick();
        nchk++;
        if (Q !== w[0]) begin
            nfail++;
            $display("FAIL blk_word got %h want %h", Q, w[0]);
        end
    endtask

    task automatic test_adv_drop();
        logic [127:0] exp [5];
        exp[0] = w[0];
        exp[1] = w[1];
        exp[2] = w[2];
        exp[3] = w[0];
        exp[4] = w[1];
        for (int k = 0; k < 5; k++) begin
            adv_en = (k != 2);
            tick();
            nchk++;
            if (Q !== exp[k]) begin
                nfail++;
                $display("FAIL advdrop_%0d got %h want %h", k, Q, exp[k]);
            end
        end
    endtask

    task automatic test_stage_switch();
        logic [127:0] x;
        logic [127:0] y;
        x = {64'h00000000000000e1, 64'h00000000000000f1};
        y = {64'h0000000000000022, 64'h0000000000000033};
        wr(WAW'(17), 1'b1, x[127:64]);
        wr(WAW'(17), 1'b0, x[63:0]);
        wr(WAW'(32), 1'b1, y[127:64]);
        wr(WAW'(32), 1'b0, y[63:0]);
        CEN = 1'b0;
        stage_counter = 3'd1;
        adv_en = 1'b1;
        tick();
        nchk++;
        if (Q !== IDENT) begin
            nfail++;
            $display("FAIL s1_w0 got %h want %h", Q, IDENT);
        end
        tick();
        nchk++;
        if (Q !== x) begin
            nfail++;
            $display("FAIL s1_w1 got %h want %h", Q, x);
        end
        stage_counter = 3'd2;
        tick();
        nchk++;
        if (Q !== y || q_valid !== 1'b1) begin
            nfail++;
            $display("FAIL s2_w0 got %h v=%b want %h v=1", Q, q_valid, y);
        end
        tick();
        nchk++;
        if (Q !== IDENT) begin
            nfail++;
            $display("FAIL s2_w1 got %h want %h", Q, IDENT);
        end
        stage_counter = 3'd5;
        tick();
        nchk++;
        if (Q !== IDENT || q_valid !== 1'b0 || Q_const !== CRST) begin
            nfail++;
            $display("FAIL s5 got Q=%h v=%b Qc=%h want %h v=0 Qc=%h",
                     Q, q_valid, Q_const, IDENT, CRST);
        end
        CEN = 1'b1;
        tick();
    endtask

    task automatic test_half_write();
        logic [127:0] e;
        e = {64'h0000000000000077, w[2][63:0]};
        wr(WAW'(2), 1'b1, 64'h77);
        CEN = 1'b0;
        stage_counter = 3'd0;
        adv_en = 1'b1;
        tick();
        tick();
        tick();
        nchk++;
        if (Q !== e) begin
            nfail++;
            $display("FAIL half_wr got %h want %h", Q, e);
        end
        CEN = 1'b1;
        tick();
    endtask

`ifdef TW_CONST_WR_EN
    task automatic test_const_write();
        logic [127:0] c2;
        c2 = {64'h0000000000000001, 64'h000ffffffff00000};
        wr({1'b1, 6'd2}, 1'b1, c2[127:64]);
        wr({1'b1, 6'd2}, 1'b0, c2[63:0]);
        CEN = 1'b0;
        stage_counter = 3'd2;
        adv_en = 1'b1;
        tick();
        nchk++;
        if (Q_const !== c2) begin
            nfail++;
            $display("FAIL const2 got %h want %h", Q_const, c2);
        end
        nchk++;
        if (Q !== {64'h22, 64'h33}) begin
            nfail++;
            $display("FAIL const_bank got %h want bank[2][0][0]", Q);
        end
        stage_counter = 3'd0;
        tick();
        nchk++;
        if (Q_const !== CRST) begin
            nfail++;
            $display("FAIL const0 got %h want %h", Q_const, CRST);
        end
        CEN = 1'b1;
        tick();
    endtask
`endif

    task automatic test_reset_midstream();
        CEN = 1'b0;
        stage_counter = 3'd0;
        adv_en = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        nchk++;
        if (Q !== IDENT || q_valid !== 1'b0 || Q_const !== CRST) begin
            nfail++;
            $display("FAIL midrst got Q=%h v=%b Qc=%h want %h v=0 Qc=%h",
                     Q, q_valid, Q_const, IDENT, CRST);
        end
        rst_n = 1'b1;
        tick();
        nchk++;
        if (Q !== IDENT || q_valid !== 1'b1) begin
            nfail++;
            $display("FAIL midrst_w0 got %h v=%b want %h v=1",
                     Q, q_valid, IDENT);
        end
        tick();
        nchk++;
        if (Q !== IDENT) begin
            nfail++;
            $display("FAIL midrst_w1 got %h want %h", Q, IDENT);
        end
        CEN = 1'b1;
        tick();
    endtask

    initial begin
        nchk = 0;
        nfail = 0;
        rst_n = 1'b1;
        CEN = 1'b1;
        stage_counter = 3'd0;
        adv_en = 1'b0;
        wr_valid = 1'b0;
        wr_half = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        w[0] = {64'h00000000000000a0, 64'h00000000000000b0};
        w[1] = {64'h0400000000000400, 64'h840fa37ec53a39e1};
        w[2] = {64'h00000000000000a2, 64'h00000000000000b2};
        w[3] = {64'h00000000000000a3, 64'h00000000000000b3};
        g1w0 = {64'h00000000000000c1, 64'h00000000000000d1};
        test_reset();
        test_stream_ident();
        test_load_stream();
        test_wr_blocked();
        test_adv_drop();
        test_stage_switch();
        test_half_write();
`ifdef TW_CONST_WR_EN
        test_const_write();
`endif
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/tw_stage_buf.md
# tw_stage_buf

Parametrised, run-time reloadable twiddle-factor buffer for the radix-16 NTT datapath. It holds one bank of twiddle words per butterfly stage, each bank split into groups. While enabled it streams one word per cycle to the butterfly array, walking index, repeat and group counters. It also presents a per-stage constant twiddle and accepts half-word (64-bit) reloads from the horizontal load bus while idle.

## Interface
- P_WIDTH, 128: twiddle word width, as a {hi, lo} pair of P_WIDTH/2 residues.
- HW_DW, 64: load-bus width; must equal P_WIDTH/2.
- NUM_STAGE, 4: number of stage banks; power of two.
- GROUPS, 4: groups per bank; power of two.
- DEPTH, 4: words per group; power of two.
- REPEAT, 16: full passes over a group before the group advances; ≥1.
- SC_WIDTH, 3: stage_counter width.
- CONST_RST, {64'hfffffbff00000001, 64'h1fffffffe0000000}: reset value of every constant entry.
- AW: derived, $clog2(NUM_STAGE*GROUPS*DEPTH); word address layout {stage, group, idx}.
- CLK  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- CEN  in  1  read enable, active low.
- stage_counter  in  SC_WIDTH  stage selected for reads.
- adv_en  in  1  counter advance qualifier; the butterfly controller asserts it in its compute states.
- wr_valid  in  1  load request.
- wr_ready  out  1  load accept; combinational, equal to CEN.
- wr_half  in  1  1 = write bits [P_WIDTH-1:HW_DW], 0 = bits [HW_DW-1:0].
- wr_addr  in  AW  target word.
- wr_data  in  HW_DW  half-word data.
- Q  out  P_WIDTH  streamed twiddle, registered.
- q_valid  out  1  Q holds a bank word, registered.
- Q_const  out  P_WIDTH  per-stage constant, registered.

## Operation
- Reset values:
  - All bank words = IDENT = {HW_DW'd1, HW_DW'd1}.
  - Q = IDENT; q_valid = 0; Q_const = CONST_RST.
  - idx, rep and grp = 0.
- Load: a write occurs when wr_valid && wr_ready. Only the selected half of word wr_addr is written. The other half is unchanged.
- Read cycle (CEN=0, stage_counter < NUM_STAGE):
  - Q <= bank[stage_counter][grp][idx]; q_valid <= 1.
  - If adv_en=1: idx increments. On wrap DEPTH-1 → 0, rep increments. On rep wrap REPEAT-1 → 0, grp increments mod GROUPS.
  - If adv_en=0: idx and rep clear to 0; grp holds.
- stage_counter ≥ NUM_STAGE with CEN=0: Q <= IDENT; q_valid <= 0; all counters clear.
- stage_counter change (registered compare against the previous value) while CEN=0: idx, rep and grp clear before the read. The first word of the new stage is entry {stage, 0, 0}.
- CEN=1: Q <= IDENT; q_valid <= 0; counters hold; Q_const holds.
- Q_const <= const[stage_counter] on every CEN=0 cycle with stage_counter < NUM_STAGE; otherwise it holds.

## Timing
- Read latency: 1 cycle from a CEN=0 edge to Q/q_valid.
- Load to read: a word written at edge N is readable from edge N+1. No read/write collision is possible because wr_ready=CEN.
- Wrap order per adv_en cycle: idx, then rep, then grp; all update on the same edge.
- Reset asserted mid-stream: outputs return to their reset values immediately. Loaded contents are lost and the banks revert to IDENT.

## Configuration
- TW_CONST_WR_EN defined:
  - A NUM_STAGE-entry constant table is writable through the load port when wr_addr MSB = 1.
  - In that mode, wr_addr[$clog2(NUM_STAGE)-1:0] selects the constant entry.
  - The address port widens to AW+1.
- TW_CONST_WR_EN undefined: constants are fixed at CONST_RST and wr_addr is AW bits.

## Test plan
- Reset then CEN=0, stage 0, adv_en=1 for 4 cycles → Q = IDENT on each cycle with q_valid=1, and Q_const = CONST_RST.
- Load all 4 words of group 0 in stage 0 (both halves: hi=0x0400000000000400, lo=0x840fa37ec53a39e1 at idx 1; other words distinct), then stream → Q sequence idx0..3 repeats exactly 16 times before grp=1 words appear.
- Drive wr_valid=1 with CEN=0 → wr_ready=0 and the word is unchanged on readback.
- adv_en drops at idx=2 → next Q is idx 0 of the same group, and grp is unchanged.
- Switch stage_counter 1→2 mid-group → the first new Q is bank[2][0][0]. Setting stage_counter=5 gives Q=IDENT with q_valid=0.
- With TW_CONST_WR_EN defined, write constant 2 as {0x0000000000000001, 0x000ffffffff00000}, then select stage 2 → Q_const updates 1 cycle later.
